mod_reduce_128: RTL and testbench
=================================

MOD_REDUCE_128 -- requirements
Module: mod_reduce_128

Interface
REQ-001 The block SHALL have these ports: clk  input  1  single clock; all state changes on rising edge.
REQ-002 The block SHALL have these ports: rst  input  1  reset, synchronous, active-low; 0 at a rising edge resets the block.
REQ-003 The block SHALL have these ports: start  input  1  request; sampled only in IDLE or FIN.
REQ-004 The block SHALL have these ports: c  input  128  product to reduce; the 128-bit product output of the 64x64 multiplier; sampled only on an accepted start.
REQ-005 The block SHALL have these ports: q  input  64  modulus; sampled only on an accepted start.
REQ-006 The block SHALL have these ports: r  output  64  remainder c mod q; valid while done=1.
REQ-007 The block SHALL have these ports: busy  output  1  high in RUN.
REQ-008 The block SHALL have these ports: done  output  1  level; high in FIN.
REQ-009 The block SHALL have these ports: err  output  1  level; high in FIN when the latched q was 0.
REQ-010 The block SHALL have one parameter: none; all widths are fixed.

Function
REQ-011 The block SHALL implement three states: IDLE, RUN and FIN; the state encoding is free.
REQ-012 In IDLE or FIN, an edge with start=1 SHALL be accepted and SHALL do all of the following: latch c into a 128-bit shift register; latch q into qreg; clear the 65-bit remainder register Rm; clear the 7-bit counter cnt; set err=0; go to RUN.
REQ-013 In RUN, each edge SHALL perform one restoring iteration:
  - T = {Rm[63:0], msb of shift register};
  - if T >= {1'b0, qreg}, then Rm = T - qreg; otherwise Rm = T;
  - shift the shift register left by 1;
  - cnt = cnt + 1.
REQ-014 T SHALL be computed in 65 bits; with Rm < qreg <= 2^64-1, T never overflows.
REQ-015 After the iteration at cnt=127, the block SHALL go to FIN; cnt wraps to 0 at that point, and the wrap is not used.
REQ-016 Latency SHALL be fixed: if start is accepted at edge k, done=1 from edge k+128 onward; there are exactly 128 RUN cycles, independent of the data.
REQ-017 start SHALL be ignored in RUN; the inputs c and q are don't-care after acceptance.
REQ-018 The block SHALL stay in FIN, holding r, done and err, until start=1 or reset.
REQ-019 Start accepted in FIN SHALL drop done and err at the same edge and begin a new RUN; back-to-back operations SHALL therefore take 129 cycles each.
REQ-020 r SHALL equal Rm[63:0] in FIN and SHALL be 0 in IDLE and RUN.
REQ-021 If qreg=0, the datapath SHALL still run 128 cycles with the comparison forced false, and in FIN SHALL give err=1 and r=0.
REQ-022 If qreg=1, the result SHALL be r=0 with err=0.
REQ-023 If c < q, the result SHALL be r=c[63:0].
REQ-024 busy SHALL be 1 exactly in RUN.
REQ-025 done and busy SHALL never both be 1.

Reset
REQ-026 On rst=0 at an edge, the block SHALL take these values: state=IDLE; Rm=0; cnt=0; shift register=0; qreg=0; err=0; so r=0, done=0, busy=0.
REQ-027 Reset SHALL take priority over start and over RUN iterations.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no output pulse.
REQ-029 After rst returns to 1, the block SHALL wait in IDLE; there is no automatic start.

Verification
REQ-030 c=100, q=7, start for 1 cycle at edge k: done rises at edge k+128 with r=2, err=0, and busy was high for edges k+1..k+128.
REQ-031 c=2^128-1, q=2^64-1: r=0.
REQ-032 q=0xFFFFFFFFFFFFFFC5, c=q*q-1: r=0xFFFFFFFFFFFFFFC4. Then c=5, q=9 applied with start in FIN: done drops at the next edge, and r=5 after 128 cycles.
REQ-033 q=0, c=12345: after 128 cycles, done=1, err=1, r=0. Then q=1, c=12345 with start: r=0, err=0.
REQ-034 Start, then rst=0 at edge k+60: at edge k+61, done=0, busy=0, r=0, and the block holds IDLE. Then a start with c=100, q=7: r=2 at exactly 128 cycles later.
REQ-035 A start pulse repeated during RUN: it is ignored, the operation completes at the original k+128, and the result is unchanged.

Source files
------------

// File: rtl/mod_reduce_128_if.sv
// mod_reduce_128_if: request/result bundle for the 128-by-64 reducer.
// master drives the operands, slave returns the remainder and status.
interface mod_reduce_128_if;
    logic         start;
    logic [127:0] c;
    logic [63:0]  q;
    logic [63:0]  r;
    logic         busy;
    logic         done;
    logic         err;

    modport master (
        output start, c, q,
        input  r, busy, done, err
    );

    modport slave (
        input  start, c, q,
        output r, busy, done, err
    );
endinterface

// File: rtl/mod_reduce_128.sv
// mod_reduce_128: c mod q for a 128-bit c and 64-bit q using
// restoring shift-subtract, one dividend bit per clock, 128 clocks.
module mod_reduce_128 (
    input  logic            clk,
    input  logic            rst,
    mod_reduce_128_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t       state;
    logic [127:0] sr;
    logic [63:0]  qreg;
    logic [63:0]  rm;
    logic [6:0]   cnt;
    logic [63:0]  r_q;
    logic         busy_q;
    logic         done_q;
    logic         err_q;

    logic [64:0]  t;
    logic         ge;
    logic [63:0]  rm_nx;

    // rm always stays below qreg, so the top bit of the 65-bit
    // remainder is never set; only the trial value needs 65 bits.
    always_comb begin
        t     = {rm, sr[127]};
        ge    = (qreg != 64'd0) && (t >= {1'b0, qreg});
        rm_nx = ge ? (t[63:0] - qreg) : t[63:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            sr     <= '0;
            qreg   <= '0;
            rm     <= '0;
            cnt    <= '0;
            r_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE, FIN: begin
                    if (bus.start) begin
                        state  <= RUN;
                        sr     <= bus.c;
                        qreg   <= bus.q;
                        rm     <= '0;
                        cnt    <= '0;
                        r_q    <= '0;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                        err_q  <= 1'b0;
                    end
                end
                RUN: begin
                    rm  <= rm_nx;
                    sr  <= {sr[126:0], 1'b0};
                    cnt <= cnt + 7'd1;
                    if (cnt == 7'd127) begin
                        state  <= FIN;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        err_q  <= (qreg == 64'd0);
                        r_q    <= (qreg == 64'd0) ? 64'd0 : rm_nx;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.r    = r_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_mod_reduce_128.sv
// tb_mod_reduce_128: directed and random operations against an
// arithmetic remainder model, with exact-latency checks.
module tb_mod_reduce_128;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mod_reduce_128_if bus ();

    mod_reduce_128 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {err, r} from plain arithmetic
    function automatic logic [64:0] ref_mod(input logic [127:0] cv,
                                            input logic [63:0] qv);
        logic [127:0] rem;
        if (qv == 64'd0) return {1'b1, 64'd0};
        rem = cv % {64'd0, qv};
        return {1'b0, rem[63:0]};
    endfunction

    // Entered at a negedge; returns at the negedge after done rises.
    task automatic run_op(input logic [127:0] cv, input logic [63:0] qv,
                          input int glitch, input string tag);
        logic [64:0] e;
        int bn;
        int both;
        e = ref_mod(cv, qv);
        bus.start = 1'b1;
        bus.c = cv;
        bus.q = qv;
        @(negedge clk);
        bus.start = 1'b0;
        bus.c = {4{$urandom}};
        bus.q = {2{$urandom}};
        chk({tag, ".acc_done"}, bus.done, 0);
        chk({tag, ".acc_r"}, bus.r, 0);
        bn = (bus.busy && !bus.done) ? 1 : 0;
        both = 0;
        for (int i = 1; i < 128; i++) begin
            if (i == glitch) begin
                bus.start = 1'b1;
                bus.c = {4{$urandom}};
                bus.q = {2{$urandom}};
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (bus.busy && !bus.done) bn++;
            if (bus.busy && bus.done) both++;
        end
        bus.start = 1'b0;
        chk({tag, ".busy_cycles"}, bn, 128);
        chk({tag, ".busy_done_overlap"}, both, 0);
        @(negedge clk);
        chk({tag, ".done"}, bus.done, 1);
        chk({tag, ".busy"}, bus.busy, 0);
        chk({tag, ".r"}, bus.r, e[63:0]);
        chk({tag, ".err"}, bus.err, e[64]);
    endtask

    initial begin
        logic [127:0] cv;
        logic [63:0]  qv;

        bus.start = 1'b0;
        bus.c = '0;
        bus.q = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.r", bus.r, 0);
        chk("rst.busy", bus.busy, 0);
        chk("rst.done", bus.done, 0);
        chk("rst.err", bus.err, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle.busy", bus.busy, 0);
        chk("idle.done", bus.done, 0);

        run_op(128'd100, 64'd7, 0, "c100q7");
        chk("c100q7.r2", bus.r, 2);

        run_op({128{1'b1}}, {64{1'b1}}, 0, "allones");
        chk("allones.r0", bus.r, 0);

        qv = 64'hFFFF_FFFF_FFFF_FFC5;
        cv = {64'd0, qv} * {64'd0, qv} - 128'd1;
        run_op(cv, qv, 0, "qsq");
        chk("qsq.rq1", bus.r, 64'hFFFF_FFFF_FFFF_FFC4);
        run_op(128'd5, 64'd9, 0, "b2b");
        chk("b2b.r5", bus.r, 5);

        run_op(128'd12345, 64'd0, 0, "q0");
        chk("q0.err1", bus.err, 1);
        run_op(128'd12345, 64'd1, 0, "q1");
        chk("q1.err0", bus.err, 0);

        run_op(128'h1_2345_6789, 64'hFFFF_0000_0000_0000, 0, "cltq");
        chk("cltq.r_eq_c", bus.r, 64'h1_2345_6789);

        // reset lands on the 60th RUN edge
        bus.start = 1'b1;
        bus.c = {4{$urandom}};
        bus.q = {2{$urandom}};
        @(negedge clk);
        bus.start = 1'b0;
        repeat (59) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort.done", bus.done, 0);
        chk("abort.busy", bus.busy, 0);
        chk("abort.r", bus.r, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort.hold_busy", bus.busy, 0);
        chk("abort.hold_done", bus.done, 0);
        run_op(128'd100, 64'd7, 0, "after_abort");
        chk("after_abort.r2", bus.r, 2);

        run_op({4{$urandom}}, {2{$urandom}}, 60, "glitch60");
        run_op({4{$urandom}}, {2{$urandom}}, 1, "glitch1");
        run_op({4{$urandom}}, {2{$urandom}}, 127, "glitch127");

        for (int i = 0; i < 12; i++) begin
            cv = {$urandom, $urandom, $urandom, $urandom};
            qv = {$urandom, $urandom};
            if (i % 3 == 0) qv = 64'($urandom_range(1, 1000));
            if (i % 3 == 1) cv = {64'd0, qv >> ($urandom_range(1, 40))};
            run_op(cv, qv, 0, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
